// File: rtl/keysw_io_ctrl.sv
// ============================================================================
//  Module   : keysw_io_ctrl
//  Purpose  : Memory-mapped KEY/SW input device. It synchronises and debounces
//             the raw inputs, keeps sticky ready/overrun status bits and drives
//             a level interrupt request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module keysw_io_chan #(
    parameter int             W       = 4,
    parameter int             DEB_CYC = 100000,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  i_raw,
    input  logic          i_data_rd,
    input  logic          i_ctrl_wr,
    input  logic          i_wr_rdy,
    input  logic          i_wr_ovr,
    input  logic          i_wr_ie,
    output logic [W-1:0]  o_deb,
    output logic          o_rdy,
    output logic          o_ovr,
    output logic          o_ie,
    output logic          o_rdy_nxt,
    output logic          o_ie_nxt
);

    localparam int               c_cnt_w    = $clog2(DEB_CYC);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_CYC - 1);

    logic [W-1:0]       s1_q, s1_d, s2_q, s2_d, deb_q, deb_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               rdy_q, rdy_d, ovr_q, ovr_d, ie_q, ie_d;
    logic               w_upd, w_clr;

    // The count is zero in the first cycle s holds a new value, so the
    // update fires in the DEB_CYC-th consecutive cycle of a stable new value.
    always_comb begin
        s1_d  = i_raw;
        s2_d  = s1_q;
        deb_d = deb_q;
        cnt_d = '0;
        w_upd = 1'b0;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == c_cnt_last) begin
            w_upd = 1'b1;
            deb_d = s2_q;
        end else if (s1_q != s2_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Clears apply first so that a same-cycle update still sets RDY.
    always_comb begin
        rdy_d = rdy_q;
        ovr_d = ovr_q;
        ie_d  = ie_q;
        w_clr = i_data_rd | (i_ctrl_wr & ~i_wr_rdy);
        if (i_ctrl_wr) begin
            if (!i_wr_rdy) rdy_d = 1'b0;
            if (!i_wr_ovr) ovr_d = 1'b0;
            ie_d = i_wr_ie;
        end
        if (i_data_rd) rdy_d = 1'b0;
        if (w_upd) begin
            if (rdy_q && !w_clr) ovr_d = 1'b1;
            rdy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            deb_q <= RST_VAL;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            ovr_q <= 1'b0;
            ie_q  <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            deb_q <= deb_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
            ovr_q <= ovr_d;
            ie_q  <= ie_d;
        end
    end

    assign o_deb     = deb_q;
    assign o_rdy     = rdy_q;
    assign o_ovr     = ovr_q;
    assign o_ie      = ie_q;
    assign o_rdy_nxt = rdy_d;
    assign o_ie_nxt  = ie_d;

endmodule

module keysw_io_ctrl #(
    parameter int            DBITS   = 16,
    parameter int            DEB_CYC = 100000,
    parameter logic [3:0]    KEY_RST = 4'hF,
    parameter logic [9:0]    SW_RST  = 10'h000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DBITS-1:0]  ADDR,
    input  logic              RE,
    input  logic              WE,
    input  logic [DBITS-1:0]  DIN,
    output logic [DBITS-1:0]  DOUT,
    output logic              SEL,
    input  logic [3:0]        KEY,
    input  logic [9:0]        SW,
    output logic              IRQ
);

    localparam logic [DBITS-1:0] c_kdata_addr = DBITS'(16'hFFF0);
    localparam logic [DBITS-1:0] c_sdata_addr = DBITS'(16'hFFF2);
    localparam logic [DBITS-1:0] c_kctrl_addr = DBITS'(16'hFFF4);
    localparam logic [DBITS-1:0] c_sctrl_addr = DBITS'(16'hFFF6);
    localparam logic [DBITS-1:0] c_dead       = DBITS'(16'hDEAD);

    logic [3:0] w_kdeb;
    logic [9:0] w_sdeb;
    logic       w_krdy, w_kovr, w_kie, w_krdy_nxt, w_kie_nxt;
    logic       w_srdy, w_sovr, w_sie, w_srdy_nxt, w_sie_nxt;
    logic       w_k_rd, w_s_rd, w_k_wr, w_s_wr;
    logic       irq_q, irq_d;
    logic       w_unused_din;

    assign w_k_rd       = RE & (ADDR == c_kdata_addr);
    assign w_s_rd       = RE & (ADDR == c_sdata_addr);
    assign w_k_wr       = WE & (ADDR == c_kctrl_addr);
    assign w_s_wr       = WE & (ADDR == c_sctrl_addr);
    assign w_unused_din = ^{DIN[DBITS-1:9], DIN[7:3], DIN[1]};

    keysw_io_chan #(.W(4), .DEB_CYC(DEB_CYC), .RST_VAL(KEY_RST)) u_key (
        .clk       (CLK),
        .rst       (RESET),
        .i_raw     (KEY),
        .i_data_rd (w_k_rd),
        .i_ctrl_wr (w_k_wr),
        .i_wr_rdy  (DIN[0]),
        .i_wr_ovr  (DIN[2]),
        .i_wr_ie   (DIN[8]),
        .o_deb     (w_kdeb),
        .o_rdy     (w_krdy),
        .o_ovr     (w_kovr),
        .o_ie      (w_kie),
        .o_rdy_nxt (w_krdy_nxt),
        .o_ie_nxt  (w_kie_nxt)
    );

    keysw_io_chan #(.W(10), .DEB_CYC(DEB_CYC), .RST_VAL(SW_RST)) u_sw (
        .clk       (CLK),
        .rst       (RESET),
        .i_raw     (SW),
        .i_data_rd (w_s_rd),
        .i_ctrl_wr (w_s_wr),
        .i_wr_rdy  (DIN[0]),
        .i_wr_ovr  (DIN[2]),
        .i_wr_ie   (DIN[8]),
        .o_deb     (w_sdeb),
        .o_rdy     (w_srdy),
        .o_ovr     (w_sovr),
        .o_ie      (w_sie),
        .o_rdy_nxt (w_srdy_nxt),
        .o_ie_nxt  (w_sie_nxt)
    );

    // Built from next-state status so IRQ moves on the same edge as RDY/IE.
    always_comb begin
        irq_d = (w_krdy_nxt & w_kie_nxt) | (w_srdy_nxt & w_sie_nxt);
    end

    always_ff @(posedge CLK) begin
        if (RESET) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    always_comb begin
        SEL  = 1'b1;
        DOUT = c_dead;
        case (ADDR)
            c_kdata_addr: DOUT = DBITS'({12'b0, w_kdeb});
            c_sdata_addr: DOUT = DBITS'({6'b0, w_sdeb});
            c_kctrl_addr: DOUT = DBITS'({7'b0, w_kie, 5'b0, w_kovr, 1'b0, w_krdy});
            c_sctrl_addr: DOUT = DBITS'({7'b0, w_sie, 5'b0, w_sovr, 1'b0, w_srdy});
            default:      SEL  = 1'b0;
        endcase
    end

    assign IRQ = irq_q;

endmodule

`default_nettype wire
